// File: rtl/dmem_bytelane.sv
// Word-organised data memory with byte-lane stores, extended loads and a zeroing sweep after reset.
// Define DMEM_MISALIGN_CHECK_EN to drop misaligned accesses and flag them on misalign.
module dmem_bytelane #(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              nop,
   input  logic              memWrite,
   input  logic [1:0]        size,
   input  logic              unsignedLoad,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       writeData,
   output logic [31:0]       readData,
   output logic              readValid,
   output logic              busy,
   output logic              misalign
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic {ST_INIT, ST_IDLE} state_t;

   state_t            state;
   logic [IDX_W-1:0]  sweep_cnt;
   logic [31:0]       mem [DEPTH_WORDS];

   logic [IDX_W-1:0]  widx;
   logic [1:0]        lane;
   logic              access;
   logic              legal;
   logic              st_en;
   logic              ld_en;
   logic [3:0]        st_be;
   logic [31:0]       st_data;

   logic              vld_p0;
   logic [31:0]       rdata_p0;
   logic [1:0]        lane_p0;
   logic [1:0]        size_p0;
   logic              uns_p0;

   logic              unused_addr;

   function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] ln);
      logic [3:0] be;
      be = 4'b0000;
      case (sz)
         SZ_B:    be = 4'b0001 << ln;
         SZ_H:    be = ln[1] ? 4'b1100 : 4'b0011;
         SZ_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Store data is replicated across lanes so each enabled lane finds its own bytes in place.
   function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] d;
      case (sz)
         SZ_B:    d = {4{wd[7:0]}};
         SZ_H:    d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] ln,
                                               input logic [1:0] sz, input logic uns);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      b = word[{ln, 3'b000} +: 8];
      h = ln[1] ? word[31:16] : word[15:0];
      case (sz)
         SZ_B:    r = {{24{b[7] & ~uns}}, b};
         SZ_H:    r = {{16{h[15] & ~uns}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   assign widx        = address[IDX_W+1:2];
   assign lane        = address[1:0];
   assign unused_addr = ^address[ADDR_W-1:IDX_W+2];

   assign access  = req & ~nop & ~busy & ~rst;
   assign st_en   = access & legal & memWrite;
   assign ld_en   = access & legal & ~memWrite;
   assign st_be   = lane_enables(size, lane);
   assign st_data = lane_data(size, writeData);

`ifdef DMEM_MISALIGN_CHECK_EN
   always_comb begin
      legal = 1'b0;
      case (size)
         SZ_B:    legal = 1'b1;
         SZ_H:    legal = ~lane[0];
         SZ_W:    legal = (lane == 2'b00);
         default: legal = 1'b0;
      endcase
   end
`else
   // Without checking, the lane functions already align halves and words down.
   assign legal = (size != 2'b11);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_INIT;
         sweep_cnt <= '0;
         busy      <= 1'b1;
      end else begin
         case (state)
            ST_INIT: begin
               sweep_cnt <= sweep_cnt + IDX_W'(1);
               if (sweep_cnt == LAST_IDX) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == ST_INIT && !rst) begin
         mem[sweep_cnt] <= '0;
      end else if (st_en) begin
         for (int b = 0; b < 4; b++) begin
            if (st_be[b]) mem[widx][8*b +: 8] <= st_data[8*b +: 8];
         end
      end
   end

   // Stage p0: raw word read and load attributes captured at the accepting edge.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         rdata_p0 <= mem[widx];
         lane_p0  <= lane;
         size_p0  <= size;
         uns_p0   <= unsignedLoad;
      end
   end

   // Stage p1: extension and the architectural read outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0    <= 1'b0;
         readValid <= 1'b0;
         readData  <= '0;
      end else begin
         vld_p0    <= ld_en;
         readValid <= vld_p0;
         if (vld_p0) readData <= load_extend(rdata_p0, lane_p0, size_p0, uns_p0);
      end
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   logic mis_p0;

   always_ff @(posedge clk) begin
      if (rst) begin
         mis_p0   <= 1'b0;
         misalign <= 1'b0;
      end else begin
         mis_p0   <= access & ~legal;
         misalign <= mis_p0;
      end
   end
`else
   assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane: directed vector table, corner sequences and a random run
// against a byte-array reference model.
module tb_dmem_bytelane;

   localparam int D = 16;

   logic        clk;
   logic        rst;
   logic        req;
   logic        nop;
   logic        memWrite;
   logic [1:0]  size;
   logic        unsignedLoad;
   logic [31:0] address;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        readValid;
   logic        busy;
   logic        misalign;

   int checks   = 0;
   int failures = 0;

   dmem_bytelane #(.DEPTH_WORDS(D), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .req(req), .nop(nop), .memWrite(memWrite), .size(size),
      .unsignedLoad(unsignedLoad), .address(address), .writeData(writeData),
      .readData(readData), .readValid(readValid), .busy(busy), .misalign(misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Reference model: byte-addressed memory, plus what the outputs should show.
   logic [7:0]  mm [D*4];
   logic        m_busy = 1'b1;
   int          m_left = D;
   logic        p_vld = 1'b0, p_mis = 1'b0;
   logic [31:0] p_data = '0;
   logic        m_rv = 1'b0, m_mis = 1'b0;
   logic [31:0] m_rd = '0;

   function automatic bit m_legal(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'b11) return 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
      if (sz == 2'b01 && a[0]) return 1'b0;
      if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b0;
`endif
      return 1'b1;
   endfunction

   function automatic int m_base(input logic [1:0] sz, input logic [31:0] a);
      int b;
      b = int'(a % (D*4));
      if (sz == 2'b01) b = b - (b % 2);
      if (sz == 2'b10) b = b - (b % 4);
      return b;
   endfunction

   function automatic int m_len(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
      logic [31:0] v;
      int          base;
      v = '0;
      base = m_base(sz, a);
      for (int i = 0; i < m_len(sz); i++) v = v | (32'(mm[base+i]) << (8*i));
      if (sz == 2'b00 && !u && v[7])  v = v | 32'hFFFF_FF00;
      if (sz == 2'b01 && !u && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      int base;
      base = m_base(sz, a);
      for (int i = 0; i < m_len(sz); i++) mm[base+i] = wd[8*i +: 8];
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, advance the model across the edge, compare all outputs.
   task automatic tick(input logic r, input logic rq, input logic n, input logic we,
                       input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] wd);
      bit acc, ok;
      rst = r; req = rq; nop = n; memWrite = we; size = sz;
      unsignedLoad = u; address = a; writeData = wd;
      acc = rq && !n && !m_busy && !r;
      ok  = m_legal(sz, a);
      @(posedge clk);
      m_rv = p_vld;
      if (p_vld) m_rd = p_data;
      m_mis = p_mis;
      p_vld = acc && ok && !we;
      if (p_vld) p_data = m_load(sz, u, a);
`ifdef DMEM_MISALIGN_CHECK_EN
      p_mis = acc && !ok;
`else
      p_mis = 1'b0;
`endif
      if (acc && ok && we) m_store(sz, a, wd);
      if (r) begin
         m_left = D; m_busy = 1'b1;
         p_vld = 1'b0; p_mis = 1'b0;
         m_rv = 1'b0; m_mis = 1'b0; m_rd = '0;
         for (int i = 0; i < D*4; i++) mm[i] = 8'h00;
      end else begin
         if (m_left > 0) m_left--;
         m_busy = (m_left != 0);
      end
      #1;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("readValid", 32'(readValid), 32'(m_rv));
      chk("readData", readData, m_rd);
      chk("misalign", 32'(misalign), 32'(m_mis));
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic acc_op(input logic we, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
      tick(1'b0, 1'b1, 1'b0, we, sz, u, a, wd);
   endtask

   // Idle cycles while busy; returns how many cycles busy stayed high.
   task automatic count_sweep(output int n);
      n = 0;
      while (busy === 1'b1 && n < 4*D) begin
         if (n == D/2) acc_op(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
         else idle();
         n++;
      end
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] a;
      logic [31:0] wd;
      logic        ld;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int n;
      tbl[0] = '{1'b0, 2'b10, 1'b0, 32'h14, 32'h0,         1'b1, 32'h0000_0000};
      tbl[1] = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF,  1'b0, 32'h0};
      tbl[2] = '{1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0080, 1'b0, 32'h0};
      tbl[3] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b1, 32'hDEAD_80EF};
      tbl[4] = '{1'b0, 2'b00, 1'b0, 32'h11, 32'h0,         1'b1, 32'hFFFF_FF80};
      tbl[5] = '{1'b0, 2'b00, 1'b1, 32'h11, 32'h0,         1'b1, 32'h0000_0080};
      tbl[6] = '{1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001, 1'b0, 32'h0};
      tbl[7] = '{1'b0, 2'b01, 1'b0, 32'h22, 32'h0,         1'b1, 32'hFFFF_8001};
      tbl[8] = '{1'b0, 2'b01, 1'b1, 32'h22, 32'h0,         1'b1, 32'h0000_8001};
      tbl[9] = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,         1'b1, 32'h8001_0000};

      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      chk("reset_readData", readData, 32'h0);
      count_sweep(n);
      chk("sweep_len", 32'(n), 32'(D));

      for (int i = 0; i < 10; i++) begin
         acc_op(tbl[i].we, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd);
         idle();
         if (tbl[i].ld) begin
            chk($sformatf("tbl%0d_valid", i), 32'(readValid), 32'h1);
            chk($sformatf("tbl%0d_data", i), readData, tbl[i].exp);
         end
      end

      acc_op(1'b1, 2'b10, 1'b0, 32'(D*4 + 4), 32'h1234_5678);
      acc_op(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
      idle();
      chk("wrap_valid", 32'(readValid), 32'h1);
      chk("wrap_data", readData, 32'h1234_5678);
      acc_op(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      acc_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      chk("nop_slot_valid", 32'(readValid), 32'h0);
      idle();
      chk("after_nop_data", readData, 32'h8001_0000);

`ifdef DMEM_MISALIGN_CHECK_EN
      acc_op(1'b1, 2'b10, 1'b0, 32'h13, 32'hFFFF_FFFF);
      idle();
      chk("mis_store_flag", 32'(misalign), 32'h1);
      chk("mis_store_valid", 32'(readValid), 32'h0);
      idle();
      chk("mis_store_pulse", 32'(misalign), 32'h0);
      acc_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      idle();
      chk("mis_mem_kept", readData, 32'hDEAD_80EF);
      acc_op(1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
      idle();
      chk("mis_half_flag", 32'(misalign), 32'h1);
      chk("mis_half_hold", readData, 32'hDEAD_80EF);
`else
      acc_op(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
      idle();
      chk("align_valid", 32'(readValid), 32'h1);
      chk("align_data", readData, 32'hDEAD_80EF);
      chk("align_flag", 32'(misalign), 32'h0);
      acc_op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
      idle();
      chk("illegal_valid", 32'(readValid), 32'h0);
      chk("illegal_flag", 32'(misalign), 32'h0);
`endif

      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, D*8 - 1));
         tick(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom());
      end

      tick(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 5; i++) idle();
      tick(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      count_sweep(n);
      chk("resweep_len", 32'(n), 32'(D));
      acc_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      idle();
      chk("resweep_zero", readData, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised single-port data memory for the MEM stage of the 5-stage pipeline. Storage is word-organised with byte-lane writes and supports byte, half and word loads and stores, with sign or zero extension of loads. Reads are registered and have one-cycle latency. After reset, a hardware sweep zeroes the array before any request is accepted.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words; must be a power of two ≥ 4.
- `ADDR_W`, 32: byte-address width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req`  in  1  access request, sampled on the clock edge.
- `nop`  in  1  pipeline bubble; when 1, `req` is ignored.
- `memWrite`  in  1  1 = store, 0 = load.
- `size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `unsignedLoad`  in  1  1 = zero-extend loads, 0 = sign-extend.
- `address`  in  ADDR_W  byte address.
- `writeData`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `readData`  out  32  registered, extended load result.
- `readValid`  out  1  1 for one cycle when `readData` holds a load result.
- `busy`  out  1  init sweep in progress; requests are ignored while 1.
- `misalign`  out  1  one-cycle flag for a dropped misaligned or illegal access.

## Operation
- **Word index** = `address[log2(DEPTH_WORDS)+1:2]`. Higher address bits are ignored, so accesses wrap modulo the array size.
- **Byte lane** = `address[1:0]`.
- **Accepted access:** `req & ~nop & ~busy & ~rst`, and the access is legal.
- **Stores:**
  - byte: write lane `address[1:0]` with `writeData[7:0]`.
  - half: write lanes {a, a+1}, where a = `{address[1],0}`, with `writeData[15:0]`.
  - word: write all four lanes.
  - Lanes that are not written keep their value.
- **Loads:**
  - Select the byte or half at the lane offset, then extend it to 32 bits using `unsignedLoad`.
  - Word loads are not extended.
- **Legality:** `size`=11 is always illegal. The access is dropped, with no write and no `readValid`.
- **State machine:** `INIT` → `IDLE`.
  - `rst` forces `INIT` and a sweep counter of 0.
  - In `INIT`: each cycle, write word[counter] = 0 and increment the counter. Leave for `IDLE` the cycle after word `DEPTH_WORDS-1` is written.
  - `busy` = (state == `INIT`).
  - `IDLE` is held until the next `rst`.
- **Reset mid-sweep:** restarts the sweep at word 0.
- **Reset values:** `readData`=0, `readValid`=0, `misalign`=0, `busy`=1 (held throughout reset).
- **Holding `readData`:** keeps its last load value until the next accepted load. Stores, nops and dropped accesses do not change it.

## Timing
- **Load latency:** load accepted at edge N → `readData` and `readValid`=1 after edge N+1. `readValid` is 0 in every other cycle.
- **Store:** memory is updated at the accepting edge.
- **Store then load:** a load to the same word on the next cycle returns the new data. There is no hazard window.
- **One access per cycle:** single port. Store and load cannot coincide, because `memWrite` selects between them.
- **Sweep length:** after `rst` falls, `busy` stays 1 for exactly `DEPTH_WORDS` cycles. The first request can be accepted at edge `DEPTH_WORDS`+1 after the first non-reset edge.
- **Flag timing:** `misalign` is asserted on the same cycle that a `readValid` would have been for that access.

## Configuration
- **`DMEM_MISALIGN_CHECK_EN` defined:**
  - A misaligned access is dropped: half with `address[0]`=1, or word with `address[1:0]`≠0. No memory write, no `readValid`.
  - `misalign` pulses 1 for one cycle, one edge after the request.
  - `size`=11 also pulses `misalign`.
- **`DMEM_MISALIGN_CHECK_EN` undefined:**
  - The address is aligned down to the access size: half ignores bit 0, word ignores bits [1:0]. The access is then performed normally.
  - `size`=11 is silently dropped.
  - `misalign` is tied to 0.

## Test plan
- **Reset and sweep:** assert `rst` 3 cycles, then release. Expect `busy`=1 for exactly `DEPTH_WORDS` cycles, then 0. A `req` issued mid-sweep produces no `readValid`. A load of word 5 after the sweep returns 0x00000000.
- **Store word and byte, load back:** store word 0xDEADBEEF @0x10, then byte 0x80 @0x11. Load word @0x10 → 0xDEAD80EF. Signed byte load @0x11 → 0xFFFFFF80. Unsigned byte load @0x11 → 0x00000080.
- **Half-word extension:** store half 0x8001 @0x22. Signed half load @0x22 → 0xFFFF8001. Unsigned half load → 0x00008001. Word load @0x20 → 0x80010000.
- **Back-to-back and wrap:** store word 0x12345678 @ (`DEPTH_WORDS`*4 + 4), then load @0x4 on the next cycle. Expect `readValid` one cycle later with 0x12345678. A nop cycle between loads gives `readValid`=0 in that slot.
- **Misalignment, macro defined:** word store @0x13 → memory unchanged, `misalign`=1 for one cycle, no `readValid`. Half load @0x21 → `misalign`=1, `readData` unchanged.
- **Misalignment, macro undefined:** word load @0x13 returns the word at 0x10 with `readValid`=1 and `misalign`=0. Reset asserted mid-sweep restarts `busy` for a full `DEPTH_WORDS` cycles.
